decode_pipe_stage: RTL
======================

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register and datapath width (>=32).
REQ-002 Parameter REG_COUNT, default 32, architectural register count (power of two); REG_ID_WIDTH = clog2(REG_COUNT).
REQ-003 Parameter CNT_WIDTH, default 16, width of the decoded-instruction counter.
REQ-004 Port clock  in  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port instruction  in  32  fetched instruction; pc_plus_four  in  DATA_WIDTH  fetch PC+4; valid_F  in  1  instruction valid.
REQ-007 Port writeback_value  in  DATA_WIDTH; writeback_id  in  REG_ID_WIDTH; reg_write_W  in  1  writeback request.
REQ-008 Port forward_value_M  in  DATA_WIDTH; forward_rs_M, forward_rt_M  in  1  select forwarded value for branch compare.
REQ-009 Port stall_E  in  1  hold E register; flush_E  in  1  load bubble into E register.
REQ-010 Port pc_src_D  out  1  redirect taken; jump_address_D  out  DATA_WIDTH  redirect target (both combinational).
REQ-011 Port rs_value_E, rt_value_E, immediate_E  out  DATA_WIDTH; rs_id_E, rt_id_E, rd_id_E  out  REG_ID_WIDTH; shamt_E  out  5.
REQ-012 Port reg_write_E, mem_to_reg_E, mem_write_E, alu_src_E, reg_dest_E, syscall_E, valid_E  out  1; alu_op_E  out  4.
REQ-013 Port decode_count  out  CNT_WIDTH  instructions passed to E since reset.

Function
REQ-014 Register file holds REG_COUNT entries; register 0 reads 0 always; writes to id 0 are ignored.
REQ-015 Write occurs at the clock edge when reg_write_W=1; a same-cycle read of writeback_id returns writeback_value (write-through bypass).
REQ-016 Immediate: zero-extended for andi/ori/xori (opcodes 0x0C/0x0D/0x0E), sign-extended to DATA_WIDTH otherwise.
REQ-017 Branch operands = forward_value_M when corresponding forward_*_M=1, else register-file read with bypass.
REQ-018 Branch target = pc_plus_four + (sign-extended imm << 2), modulo 2^DATA_WIDTH.
REQ-019 j/jal target = {pc_plus_four[DATA_WIDTH-1:28], instr[25:0], 2'b00}; jr target = rs operand.
REQ-020 Taken conditions: beq rs==rt; bne rs!=rt; blez rs<=0; bgtz rs>0; bltz rs<0; bgez rs>=0 (signed); j/jal/jr always.
REQ-021 pc_src_D = taken & valid_F; jump_address_D = computed target whenever pc_src_D=1, otherwise don't-care.
REQ-022 E register update priority: reset > flush_E > stall_E > load.
REQ-023 flush_E: all E outputs 0 (bubble, valid_E=0), regardless of stall_E.
REQ-024 stall_E (no flush): all E outputs hold.
REQ-025 Load: E outputs take decoded values; valid_E = valid_F; control outputs forced 0 when valid_F=0.
REQ-026 Latency: D to E exactly one cycle.
REQ-027 decode_count increments by 1 on each load with valid_F=1; saturates at all-ones (no wrap); unchanged on stall/flush.
REQ-028 Undefined opcodes decode as bubble controls (all 0) with valid_E following valid_F.

Reset
REQ-029 reset=1 at a clock edge clears all E outputs to 0, valid_E to 0, decode_count to 0, all registers to 0; overrides concurrent writeback, stall and flush.
REQ-030 Reset mid-stream leaves no in-flight writeback committed in that cycle.

Structure
REQ-031 Shared package decode_pkg holds opcode/funct constants, alu_op encodings, branch-variant enum and an E-stage control struct.
REQ-032 Register file is sub-module decode_regfile (parametrised DATA_WIDTH, REG_COUNT, with bypass); decode, branch and pipeline logic stay in top.

Verification
REQ-033 Write R5=0x1234 with same-cycle read of rs=5 -> rs_value_E=0x1234 next cycle; write R0=0xFFFF -> R0 reads 0.
REQ-034 beq rs=rt=R3 (both 7), imm=-1, pc_plus_four=0x100 -> pc_src_D=1, jump_address_D=0xFC; bne same -> pc_src_D=0.
REQ-035 bgtz rs, register 0 but forward_rs_M=1, forward_value_M=5 -> pc_src_D=1.
REQ-036 Load addi; assert stall_E 3 cycles -> E outputs stable; assert stall_E and flush_E together -> valid_E=0, controls 0.
REQ-037 ori imm=0x8000 -> immediate_E=0x00008000; addi imm=0x8000 -> immediate_E=0xFFFF8000.
REQ-038 CNT_WIDTH=4, 20 valid loads -> decode_count=15; reset mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct codes, ALU encodings, branch kinds and
// the control bundle carried into the E stage.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  typedef enum logic [3:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BLEZ,
    BR_BGTZ,
    BR_BLTZ,
    BR_BGEZ,
    BR_J,
    BR_JR
  } branch_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dest;
    logic       syscall;
    logic [3:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t r_ctrl(input logic [3:0] op);
    ctrl_t c;
    c           = '0;
    c.reg_write = 1'b1;
    c.reg_dest  = 1'b1;
    c.alu_op    = op;
    return c;
  endfunction

  function automatic ctrl_t i_ctrl(input logic [3:0] op);
    ctrl_t c;
    c           = '0;
    c.reg_write = 1'b1;
    c.alu_src   = 1'b1;
    c.alu_op    = op;
    return c;
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: R0 hard-wired to zero, two read ports with
// write-through bypass of the same-cycle writeback.
module decode_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  localparam int ID_WIDTH  = $clog2(REG_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ID_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ID_WIDTH-1:0]   raddr_a,
  input  logic [ID_WIDTH-1:0]   raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic                  wr_en;

  assign wr_en = we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    if (wr_en && (waddr == raddr_a)) rdata_a = wdata;
    if (wr_en && (waddr == raddr_b)) rdata_b = wdata;
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode stage: instruction decode, register read, early branch/jump resolution
// and the D->E pipeline register with stall/flush and a saturating decode count.
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_COUNT     = 32,
  parameter int CNT_WIDTH     = 16,
  localparam int REG_ID_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             instruction,
  input  logic [DATA_WIDTH-1:0]   pc_plus_four,
  input  logic                    valid_F,
  input  logic [DATA_WIDTH-1:0]   writeback_value,
  input  logic [REG_ID_WIDTH-1:0] writeback_id,
  input  logic                    reg_write_W,
  input  logic [DATA_WIDTH-1:0]   forward_value_M,
  input  logic                    forward_rs_M,
  input  logic                    forward_rt_M,
  input  logic                    stall_E,
  input  logic                    flush_E,
  output logic                    pc_src_D,
  output logic [DATA_WIDTH-1:0]   jump_address_D,
  output logic [DATA_WIDTH-1:0]   rs_value_E,
  output logic [DATA_WIDTH-1:0]   rt_value_E,
  output logic [DATA_WIDTH-1:0]   immediate_E,
  output logic [REG_ID_WIDTH-1:0] rs_id_E,
  output logic [REG_ID_WIDTH-1:0] rt_id_E,
  output logic [REG_ID_WIDTH-1:0] rd_id_E,
  output logic [4:0]              shamt_E,
  output logic                    reg_write_E,
  output logic                    mem_to_reg_E,
  output logic                    mem_write_E,
  output logic                    alu_src_E,
  output logic                    reg_dest_E,
  output logic                    syscall_E,
  output logic                    valid_E,
  output logic [3:0]              alu_op_E,
  output logic [CNT_WIDTH-1:0]    decode_count
);

  logic [5:0]              opcode, funct;
  logic [4:0]              rs_f, rt_f, rd_f;
  logic [REG_ID_WIDTH-1:0] rs_id, rt_id, rd_id;
  logic [DATA_WIDTH-1:0]   imm_sext, imm_val;
  logic [DATA_WIDTH-1:0]   rs_rf, rt_rf, rs_op, rt_op;
  logic [DATA_WIDTH-1:0]   br_target, j_target;
  ctrl_t                   ctrl;
  branch_t                 br;
  logic                    taken;

  assign opcode = instruction[31:26];
  assign rs_f   = instruction[25:21];
  assign rt_f   = instruction[20:16];
  assign rd_f   = instruction[15:11];
  assign funct  = instruction[5:0];
  assign rs_id  = REG_ID_WIDTH'(rs_f);
  assign rt_id  = REG_ID_WIDTH'(rt_f);
  assign rd_id  = REG_ID_WIDTH'(rd_f);

  assign imm_sext = {{(DATA_WIDTH-16){instruction[15]}}, instruction[15:0]};
  assign imm_val  = is_zext_op(opcode) ? {{(DATA_WIDTH-16){1'b0}}, instruction[15:0]} : imm_sext;

  decode_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (reg_write_W),
    .waddr  (writeback_id),
    .wdata  (writeback_value),
    .raddr_a(rs_id),
    .raddr_b(rt_id),
    .rdata_a(rs_rf),
    .rdata_b(rt_rf)
  );

  always_comb begin
    ctrl = '0;
    br   = BR_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: ctrl = r_ctrl(ALU_ADD);
          F_SUB, F_SUBU: ctrl = r_ctrl(ALU_SUB);
          F_AND:         ctrl = r_ctrl(ALU_AND);
          F_OR:          ctrl = r_ctrl(ALU_OR);
          F_XOR:         ctrl = r_ctrl(ALU_XOR);
          F_NOR:         ctrl = r_ctrl(ALU_NOR);
          F_SLT:         ctrl = r_ctrl(ALU_SLT);
          F_SLTU:        ctrl = r_ctrl(ALU_SLTU);
          F_SLL:         ctrl = r_ctrl(ALU_SLL);
          F_SRL:         ctrl = r_ctrl(ALU_SRL);
          F_SRA:         ctrl = r_ctrl(ALU_SRA);
          F_JR:          br   = BR_JR;
          F_SYSCALL:     ctrl.syscall = 1'b1;
          default:       ctrl = '0;
        endcase
      end
      OP_REGIMM: begin
        if (rt_f == 5'd0)      br = BR_BLTZ;
        else if (rt_f == 5'd1) br = BR_BGEZ;
      end
      OP_J, OP_JAL:        br   = BR_J;
      OP_BEQ:              br   = BR_BEQ;
      OP_BNE:              br   = BR_BNE;
      OP_BLEZ:             br   = BR_BLEZ;
      OP_BGTZ:             br   = BR_BGTZ;
      OP_ADDI, OP_ADDIU:   ctrl = i_ctrl(ALU_ADD);
      OP_SLTI:             ctrl = i_ctrl(ALU_SLT);
      OP_SLTIU:            ctrl = i_ctrl(ALU_SLTU);
      OP_ANDI:             ctrl = i_ctrl(ALU_AND);
      OP_ORI:              ctrl = i_ctrl(ALU_OR);
      OP_XORI:             ctrl = i_ctrl(ALU_XOR);
      OP_LUI:              ctrl = i_ctrl(ALU_LUI);
      OP_LW: begin
        ctrl            = i_ctrl(ALU_ADD);
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      default: ctrl = '0;
    endcase
  end

  // Branches resolve here, so a forwarded M-stage result overrides the register read.
  assign rs_op     = forward_rs_M ? forward_value_M : rs_rf;
  assign rt_op     = forward_rt_M ? forward_value_M : rt_rf;
  assign br_target = pc_plus_four + (imm_sext << 2);
  assign j_target  = {pc_plus_four[DATA_WIDTH-1:28], instruction[25:0], 2'b00};

  always_comb begin
    taken          = 1'b0;
    jump_address_D = br_target;
    case (br)
      BR_BEQ:  taken = (rs_op == rt_op);
      BR_BNE:  taken = (rs_op != rt_op);
      BR_BLEZ: taken = rs_op[DATA_WIDTH-1] || (rs_op == '0);
      BR_BGTZ: taken = !rs_op[DATA_WIDTH-1] && (rs_op != '0);
      BR_BLTZ: taken = rs_op[DATA_WIDTH-1];
      BR_BGEZ: taken = !rs_op[DATA_WIDTH-1];
      BR_J: begin
        taken          = 1'b1;
        jump_address_D = j_target;
      end
      BR_JR: begin
        taken          = 1'b1;
        jump_address_D = rs_op;
      end
      default: taken = 1'b0;
    endcase
  end

  assign pc_src_D = taken && valid_F;

  ctrl_t                   ctrl_e_q, ctrl_e_d;
  logic                    valid_e_q, valid_e_d;
  logic [DATA_WIDTH-1:0]   rs_val_e_q, rs_val_e_d, rt_val_e_q, rt_val_e_d;
  logic [DATA_WIDTH-1:0]   imm_e_q, imm_e_d;
  logic [REG_ID_WIDTH-1:0] rs_id_e_q, rs_id_e_d, rt_id_e_q, rt_id_e_d, rd_id_e_q, rd_id_e_d;
  logic [4:0]              shamt_e_q, shamt_e_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;

  always_comb begin
    ctrl_e_d   = ctrl_e_q;
    valid_e_d  = valid_e_q;
    rs_val_e_d = rs_val_e_q;
    rt_val_e_d = rt_val_e_q;
    imm_e_d    = imm_e_q;
    rs_id_e_d  = rs_id_e_q;
    rt_id_e_d  = rt_id_e_q;
    rd_id_e_d  = rd_id_e_q;
    shamt_e_d  = shamt_e_q;
    count_d    = count_q;
    if (flush_E) begin
      ctrl_e_d   = '0;
      valid_e_d  = 1'b0;
      rs_val_e_d = '0;
      rt_val_e_d = '0;
      imm_e_d    = '0;
      rs_id_e_d  = '0;
      rt_id_e_d  = '0;
      rd_id_e_d  = '0;
      shamt_e_d  = '0;
    end else if (!stall_E) begin
      ctrl_e_d   = valid_F ? ctrl : '0;
      valid_e_d  = valid_F;
      rs_val_e_d = rs_rf;
      rt_val_e_d = rt_rf;
      imm_e_d    = imm_val;
      rs_id_e_d  = rs_id;
      rt_id_e_d  = rt_id;
      rd_id_e_d  = rd_id;
      shamt_e_d  = instruction[10:6];
      if (valid_F && (count_q != '1)) count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_e_q   <= '0;
      valid_e_q  <= 1'b0;
      rs_val_e_q <= '0;
      rt_val_e_q <= '0;
      imm_e_q    <= '0;
      rs_id_e_q  <= '0;
      rt_id_e_q  <= '0;
      rd_id_e_q  <= '0;
      shamt_e_q  <= '0;
      count_q    <= '0;
    end else begin
      ctrl_e_q   <= ctrl_e_d;
      valid_e_q  <= valid_e_d;
      rs_val_e_q <= rs_val_e_d;
      rt_val_e_q <= rt_val_e_d;
      imm_e_q    <= imm_e_d;
      rs_id_e_q  <= rs_id_e_d;
      rt_id_e_q  <= rt_id_e_d;
      rd_id_e_q  <= rd_id_e_d;
      shamt_e_q  <= shamt_e_d;
      count_q    <= count_d;
    end
  end

  assign rs_value_E   = rs_val_e_q;
  assign rt_value_E   = rt_val_e_q;
  assign immediate_E  = imm_e_q;
  assign rs_id_E      = rs_id_e_q;
  assign rt_id_E      = rt_id_e_q;
  assign rd_id_E      = rd_id_e_q;
  assign shamt_E      = shamt_e_q;
  assign reg_write_E  = ctrl_e_q.reg_write;
  assign mem_to_reg_E = ctrl_e_q.mem_to_reg;
  assign mem_write_E  = ctrl_e_q.mem_write;
  assign alu_src_E    = ctrl_e_q.alu_src;
  assign reg_dest_E   = ctrl_e_q.reg_dest;
  assign syscall_E    = ctrl_e_q.syscall;
  assign alu_op_E     = ctrl_e_q.alu_op;
  assign valid_E      = valid_e_q;
  assign decode_count = count_q;

endmodule
